// File: rtl/parity_checker.sv
// UART RX data/parity stage: samples DATA_BITS data bits plus parity at bit centre, checks parity.
// Optional: define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around bit centre.
module parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxin,
  input  logic                 baud_tick,
  input  logic                 startbit_ok,
  output logic [DATA_BITS-1:0] dout1,
  output logic                 checkstop,
  output logic                 paritybiterror,
  output logic                 busy
);

  localparam int   TW  = $clog2(OVERSAMPLE);
  localparam int   BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic ODD = 1'(PARITY_ODD);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t               r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pbit;

  logic w_wrap;
  logic w_take;
  logic w_bit;
  logic w_pass;

  assign w_wrap = baud_tick && (r_tick_cnt == TW'(OVERSAMPLE-1));
  assign w_pass = ((^r_shift) ^ r_pbit) == ODD;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic r_v0;
  logic r_v1;

  // Two early samples are held; the bit value resolves on the third.
  assign w_take = baud_tick && (r_tick_cnt == TW'(OVERSAMPLE/2));
  assign w_bit  = (r_v0 & r_v1) | (r_v0 & rxin) | (r_v1 & rxin);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else if (baud_tick && (r_state == DATA || r_state == PARITY)) begin
      if (r_tick_cnt == TW'(OVERSAMPLE/2-2)) r_v0 <= rxin;
      if (r_tick_cnt == TW'(OVERSAMPLE/2-1)) r_v1 <= rxin;
    end
  end
`else
  assign w_take = baud_tick && (r_tick_cnt == TW'(OVERSAMPLE/2-1));
  assign w_bit  = rxin;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_tick_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_pbit         <= 1'b0;
      dout1          <= '0;
      checkstop      <= 1'b0;
      paritybiterror <= 1'b0;
      busy           <= 1'b0;
    end else begin
      if (r_state != IDLE && baud_tick)
        r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (startbit_ok) begin
            r_state        <= DATA;
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            paritybiterror <= 1'b0;
            busy           <= 1'b1;
          end
        end
        DATA: begin
          if (w_take) r_shift[r_bit_cnt] <= w_bit;
          if (w_wrap) begin
            if (r_bit_cnt == BW'(DATA_BITS-1)) r_state <= PARITY;
            else r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_take) r_pbit <= w_bit;
          if (w_wrap) begin
            if (w_pass) begin
              r_state   <= STOP;
              dout1     <= r_shift;
              checkstop <= 1'b1;
            end else begin
              r_state        <= IDLE;
              dout1          <= '0;
              paritybiterror <= 1'b1;
              busy           <= 1'b0;
            end
          end
        end
        STOP: begin
          if (w_wrap) begin
            r_state   <= IDLE;
            checkstop <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_checker.sv
// Bench for parity_checker: even- and odd-parity instances driven by directed frames,
// with a frame-level expectation model compared on every falling clock edge.
module tb_parity_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rxin = 1'b1;
  logic baud_tick = 1'b0;
  logic startbit_ok = 1'b0;

  logic [7:0] dout_e, dout_o;
  logic cs_e, cs_o, err_e, err_o, busy_e, busy_o;

  always #5 clk = ~clk;

  parity_checker #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset(reset), .rxin(rxin), .baud_tick(baud_tick), .startbit_ok(startbit_ok),
    .dout1(dout_e), .checkstop(cs_e), .paritybiterror(err_e), .busy(busy_e)
  );

  parity_checker #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .rxin(rxin), .baud_tick(baud_tick), .startbit_ok(startbit_ok),
    .dout1(dout_o), .checkstop(cs_o), .paritybiterror(err_o), .busy(busy_o)
  );

  int tests = 0;
  int fails = 0;
  int cs_cycles = 0;
  logic chk_on = 1'b0;
  logic chk_odd = 1'b1;

  // Expected outputs, index 0 = even instance, 1 = odd instance
  logic [7:0] e_dout [2];
  logic       e_cs   [2];
  logic       e_err  [2];
  logic       e_busy [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("even.dout1", dout_e, e_dout[0]);
      check("even.checkstop", cs_e, e_cs[0]);
      check("even.perr", err_e, e_err[0]);
      check("even.busy", busy_e, e_busy[0]);
      if (chk_odd) begin
        check("odd.dout1", dout_o, e_dout[1]);
        check("odd.checkstop", cs_o, e_cs[1]);
        check("odd.perr", err_o, e_err[1]);
        check("odd.busy", busy_o, e_busy[1]);
      end
      if (cs_e) cs_cycles++;
    end
  end

  task automatic exp_reset();
    for (int k = 0; k < 2; k++) begin
      e_dout[k] = '0; e_cs[k] = 1'b0; e_err[k] = 1'b0; e_busy[k] = 1'b0;
    end
  endtask

  task automatic clk1(input logic t, input logic sb, input logic rx);
    baud_tick = t; startbit_ok = sb; rxin = rx;
    @(posedge clk); #1;
    baud_tick = 1'b0; startbit_ok = 1'b0;
  endtask

  // Value the receiver must capture given a one-tick glitch at bit g's centre
  function automatic logic [7:0] sampled(input logic [7:0] d, input int g);
`ifdef UART_RX_MAJORITY_VOTE_EN
    return d;
`else
    logic [7:0] one;
    one = 8'd1;
    return (g >= 0) ? (d ^ (one << g)) : d;
`endif
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic p, input int glitch,
                            input logic start_tick, input logic noise,
                            input logic short_tail, input int abort_bit);
    logic [8:0] bits;
    logic [7:0] sd;
    logic       pass [2];
    logic       rx, sb;
    bits = {p, d};
    sd   = sampled(d, glitch);
    for (int k = 0; k < 2; k++) pass[k] = (((^sd) ^ p) == (k == 1));

    clk1(start_tick, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin e_busy[k] = 1'b1; e_err[k] = 1'b0; end

    for (int b = 0; b < 9; b++)
      for (int t = 0; t < 16; t++)
        for (int c = 0; c < 4; c++) begin
          if (b == abort_bit && t == 0 && c == 1) begin
            reset = 1'b0;
            exp_reset();
            #2;
            check("abort.dout1", dout_e, 0);
            check("abort.busy", busy_e, 0);
            check("abort.checkstop", cs_e, 0);
            check("abort.perr", err_e, 0);
            @(posedge clk); #1;
            reset = 1'b1;
            return;
          end
          rx = bits[b];
          if (b == glitch && t == 7 && c == 0) rx = ~rx;
          sb = noise && b == 3 && t == 5 && c == 2;
          clk1(c == 0, sb, rx);
          if (b == 8 && t == 15 && c == 0)
            for (int k = 0; k < 2; k++) begin
              if (pass[k]) begin
                e_cs[k] = 1'b1; e_dout[k] = sd;
              end else begin
                e_err[k] = 1'b1; e_dout[k] = '0; e_busy[k] = 1'b0;
              end
            end
        end

    for (int t = 0; t < 16; t++)
      for (int c = 0; c < 4; c++)
        if (!(short_tail && t == 15 && c > 0)) begin
          sb = noise && ((t == 8 && c == 2) || (t == 15 && c == 0));
          clk1(c == 0, sb, 1'b1);
          if (t == 15 && c == 0)
            for (int k = 0; k < 2; k++) begin e_cs[k] = 1'b0; e_busy[k] = 1'b0; end
        end
  endtask

  task automatic gap();
    repeat (5) clk1(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_reset();
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.dout1", dout_e, 0);
    check("rst.busy", busy_e, 0);
    check("rst.checkstop", cs_e, 0);
    reset = 1'b1;
    gap();

    // Good even frame
    cs_cycles = 0;
    send_frame(8'hA5, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);
    check("t1.dout1", dout_e, 8'hA5);
    check("t1.perr", err_e, 0);
    check("t1.cs_cycles", cs_cycles, 64);
    check("t1.busy", busy_e, 0);
    gap();

    // Bad parity, started with a coincident baud_tick; then a good frame clears the error
    cs_cycles = 0;
    send_frame(8'h01, 1'b0, -1, 1'b1, 1'b0, 1'b0, -1);
    check("t2.perr", err_e, 1);
    check("t2.dout1", dout_e, 8'h00);
    check("t2.cs_cycles", cs_cycles, 0);
    gap();
    send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);
    check("t2b.perr", err_e, 0);
    check("t2b.dout1", dout_e, 8'h3C);
    gap();

    // Reset mid-frame, then the same byte again
    send_frame(8'h5A, 1'b0, -1, 1'b0, 1'b0, 1'b0, 4);
    gap();
    send_frame(8'h5A, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);
    check("t4.dout1", dout_e, 8'h5A);
    gap();

    // Stray startbit_ok pulses; the odd instance fails this frame and would react to them
    chk_odd = 1'b0;
    send_frame(8'h81, 1'b0, -1, 1'b0, 1'b1, 1'b1, -1);
    check("t5.dout1", dout_e, 8'h81);
    check("t5.perr", err_e, 0);
    // Next frame starts one clock after checkstop falls, with a glitch at bit 2
    send_frame(8'h0F, 1'b0, 2, 1'b0, 1'b0, 1'b0, -1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    check("t6.dout1", dout_e, 8'h0F);
    check("t6.perr", err_e, 0);
`else
    check("t6.perr", err_e, 1);
    check("t6.dout1", dout_e, 8'h00);
`endif
    gap();

    // Odd-parity instance after a fresh reset
    reset = 1'b0;
    exp_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    chk_odd = 1'b1;
    gap();
    send_frame(8'hFF, 1'b1, -1, 1'b0, 1'b0, 1'b0, -1);
    check("t3.odd.dout1", dout_o, 8'hFF);
    check("t3.odd.perr", err_o, 0);
    check("t3.even.perr", err_e, 1);
    gap();
    send_frame(8'hFF, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);
    check("t3b.odd.perr", err_o, 1);
    check("t3b.odd.dout1", dout_o, 8'h00);
    check("t3b.even.dout1", dout_e, 8'hFF);
    gap();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
